// File: rtl/uart_boot_ctrl_if.sv
// uart_boot_ctrl_if
// Bundles the UART byte stream, the instruction-memory write port and the
// boot status lines of the boot-loader sequencer.
//   rx_data/rx_valid : received byte and its one-cycle strobe
//   mem_addr/mem_wdata/mem_we/mem_ready : memory write request and acceptance
//   cpu_reset/boot_done/boot_error : CPU hold, load-complete flag, error pulse
// Modports: slave is the sequencer side, master is the UART/memory/CPU side.
interface uart_boot_ctrl_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_ready;
  logic        cpu_reset;
  logic        boot_done;
  logic        boot_error;

  modport slave (
    input  rx_data, rx_valid, mem_ready,
    output mem_addr, mem_wdata, mem_we, cpu_reset, boot_done, boot_error
  );

  modport master (
    output rx_data, rx_valid, mem_ready,
    input  mem_addr, mem_wdata, mem_we, cpu_reset, boot_done, boot_error
  );
endinterface

// File: rtl/uart_boot_ctrl.sv
// uart_boot_ctrl
// Boot-loader sequencer: hunts the UART byte stream for the MAGIC sync word,
// reads a big-endian word count, writes that many big-endian words to
// consecutive addresses starting at BASE_ADDR, then releases the CPU.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous active-high reset, clears all state
//   bus   : uart_boot_ctrl_if.slave (rx byte stream, memory write port,
//           cpu_reset / boot_done / boot_error status)
module uart_boot_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] MAGIC     = 32'h4341_4645,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clock,
  input  logic              reset,
  uart_boot_ctrl_if.slave   bus
);

  localparam logic [31:0] MAX_COUNT = 32'(MAX_WORDS);

  typedef enum logic [1:0] {SYNC, LEN, LOAD, DONE} state_t;

  state_t      state;
  logic [31:0] sr;
  logic [1:0]  byte_cnt;
  logic [31:0] word_cnt;
  logic [31:0] word_total;

  logic [31:0] shifted;
  logic        accept;
  logic        word_done;
  logic        last_accept;

  assign shifted     = {sr[23:0], bus.rx_data};
  assign accept      = bus.mem_we && bus.mem_ready;
  assign word_done   = bus.rx_valid && (byte_cnt == 2'd3);
  assign last_accept = accept && ((word_cnt + 32'd1) == word_total);

  // Sequencer. Every output is registered here. In LOAD the acceptance of the
  // pending write and the completion of the next word are resolved in the
  // same edge, so a word landing exactly on an acceptance hands off without
  // a bubble; only a completion with a still-unaccepted write is an overrun.
  // Returning to SYNC clears the shift register so the hunt for the sync word
  // only looks at bytes received after the failure.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= SYNC;
      sr             <= 32'd0;
      byte_cnt       <= 2'd0;
      word_cnt       <= 32'd0;
      word_total     <= 32'd0;
      bus.mem_addr   <= BASE_ADDR;
      bus.mem_wdata  <= 32'd0;
      bus.mem_we     <= 1'b0;
      bus.cpu_reset  <= 1'b1;
      bus.boot_done  <= 1'b0;
      bus.boot_error <= 1'b0;
    end else begin
      bus.boot_error <= 1'b0;
      case (state)
        SYNC: begin
          if (bus.rx_valid) begin
            sr <= shifted;
            if (shifted == MAGIC) begin
              byte_cnt <= 2'd0;
              state    <= LEN;
            end
          end
        end

        LEN: begin
          if (bus.rx_valid) begin
            sr       <= shifted;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (shifted == 32'd0) begin
                state         <= DONE;
                bus.cpu_reset <= 1'b0;
                bus.boot_done <= 1'b1;
              end else if (shifted > MAX_COUNT) begin
                bus.boot_error <= 1'b1;
                sr             <= 32'd0;
                state          <= SYNC;
              end else begin
                word_cnt     <= 32'd0;
                word_total   <= shifted;
                bus.mem_addr <= BASE_ADDR;
                state        <= LOAD;
              end
            end
          end
        end

        LOAD: begin
          if (bus.rx_valid) begin
            sr       <= shifted;
            byte_cnt <= byte_cnt + 2'd1;
          end
          if (accept) begin
            word_cnt   <= word_cnt + 32'd1;
            bus.mem_we <= 1'b0;
          end
          if (last_accept) begin
            state         <= DONE;
            bus.cpu_reset <= 1'b0;
            bus.boot_done <= 1'b1;
          end else if (word_done) begin
            if (bus.mem_we && !accept) begin
              bus.boot_error <= 1'b1;
              bus.mem_we     <= 1'b0;
              sr             <= 32'd0;
              byte_cnt       <= 2'd0;
              state          <= SYNC;
            end else begin
              bus.mem_wdata <= shifted;
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= BASE_ADDR + ((word_cnt + {31'd0, accept}) << 2);
            end
          end
        end

        DONE: begin
          state <= DONE;
        end

        default: begin
          state <= SYNC;
        end
      endcase
    end
  end

endmodule
